// File: rtl/status_register_unit_if.sv
// EX-stage flag-source bundle for the status register unit.
// The EX stage drives it through master; the SR unit samples it through slave.
interface status_register_unit_if #(
  parameter int WIDTH = 32
);
  logic             ex_valid;
  logic             ex_s;
  logic [1:0]       ex_op_class;
  logic [WIDTH-1:0] ex_result;
  logic             ex_carry;
  logic             ex_overflow;
  logic             ex_shift_carry;
  logic [3:0]       msr_data;

  modport master (
    output ex_valid, ex_s, ex_op_class, ex_result,
    output ex_carry, ex_overflow, ex_shift_carry, msr_data
  );

  modport slave (
    input ex_valid, ex_s, ex_op_class, ex_result,
    input ex_carry, ex_overflow, ex_shift_carry, msr_data
  );
endinterface

// File: rtl/status_register_unit.sv
// NZCV producer with same-cycle forwarding and exception save/restore.
// Define SR_UPDATE_COUNT_EN to build the committed-update counter.
module status_register_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  status_register_unit_if.slave ex,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exc_entry,
  input  logic                  exc_return,
  output logic [3:0]            sr_out,
  output logic [3:0]            sr_fwd,
  output logic                  sr_updated,
  output logic [15:0]           upd_count
);

  logic [3:0] sr;
  logic [3:0] saved_sr;
  logic [3:0] nzcv;
  logic       commit;
  logic       upd;
  logic       n;
  logic       z;

  assign commit = ex.ex_valid & ex.ex_s
                & ~stall & ~flush;
  assign n      = ex.ex_result[WIDTH-1];
  assign z      = ~|ex.ex_result;
  assign upd    = commit & ~exc_return;

  always_comb begin
    nzcv = sr;
    unique case (ex.ex_op_class)
      2'b00: nzcv = {n, z, ex.ex_carry, ex.ex_overflow};
      2'b01: nzcv = {n, z, ex.ex_shift_carry, sr[0]};
      2'b10: nzcv = {n, z, sr[1:0]};
      2'b11: nzcv = ex.msr_data;
    endcase
  end

  // Return outranks a concurrent commit, so priority, not unique.
  always_comb begin
    sr_fwd = sr;
    priority case (1'b1)
      exc_return: sr_fwd = saved_sr;
      commit:     sr_fwd = nzcv;
      default:    sr_fwd = sr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= 4'b0000;
      saved_sr   <= 4'b0000;
      sr_updated <= 1'b0;
    end else begin
      sr         <= sr_fwd;
      sr_updated <= upd;
      if (exc_entry && !exc_return)
        saved_sr <= sr_fwd;
    end
  end

  assign sr_out = sr;

`ifdef SR_UPDATE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      upd_count <= 16'h0000;
    else if (upd)
      upd_count <= upd_count + 16'h0001;
  end
`else
  assign upd_count = 16'h0000;
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// Randomised self-checking bench for status_register_unit.
// Reference model keeps SR state as plain variables updated by the flag rules.
module tb_status_register_unit;

  localparam int W = 32;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        exc_entry;
  logic        exc_return;
  logic [3:0]  sr_out;
  logic [3:0]  sr_fwd;
  logic        sr_updated;
  logic [15:0] upd_count;

  status_register_unit_if #(.WIDTH(W)) exi ();

  status_register_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex         (exi.slave),
    .stall      (stall),
    .flush      (flush),
    .exc_entry  (exc_entry),
    .exc_return (exc_return),
    .sr_out     (sr_out),
    .sr_fwd     (sr_fwd),
    .sr_updated (sr_updated),
    .upd_count  (upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [3:0] m_sr;
  logic [3:0] m_saved;
  logic       m_upd;
  int         m_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic drv(
    input logic v, input logic s,
    input logic [1:0] cls, input logic [31:0] res,
    input logic c, input logic ov, input logic sc,
    input logic [3:0] msr,
    input logic st, input logic fl,
    input logic en, input logic rt);
    exi.ex_valid       = v;
    exi.ex_s           = s;
    exi.ex_op_class    = cls;
    exi.ex_result      = res;
    exi.ex_carry       = c;
    exi.ex_overflow    = ov;
    exi.ex_shift_carry = sc;
    exi.msr_data       = msr;
    stall              = st;
    flush              = fl;
    exc_entry          = en;
    exc_return         = rt;
  endtask

  // Flags an instruction would produce, from the class rules.
  function automatic logic [3:0] flags_of(input logic [3:0] cur);
    logic nf;
    logic zf;
    nf = exi.ex_result[W-1];
    zf = (exi.ex_result == 0);
    case (exi.ex_op_class)
      2'd0:    return {nf, zf, exi.ex_carry, exi.ex_overflow};
      2'd1:    return {nf, zf, exi.ex_shift_carry, cur[0]};
      2'd2:    return {nf, zf, cur[1], cur[0]};
      default: return exi.msr_data;
    endcase
  endfunction

  // One clock: check forward value, advance model, check registers.
  task automatic cyc();
    logic       takes;
    logic [3:0] nxt;
    takes = exi.ex_valid && exi.ex_s && !stall && !flush;
    if (exc_return)
      nxt = m_saved;
    else if (takes)
      nxt = flags_of(m_sr);
    else
      nxt = m_sr;
    #1;
    check("sr_fwd", {28'd0, sr_fwd}, {28'd0, nxt});
    @(posedge clk);
    m_upd = takes && !exc_return;
    if (exc_entry && !exc_return)
      m_saved = nxt;
    m_sr = nxt;
`ifdef SR_UPDATE_COUNT_EN
    if (m_upd)
      m_cnt = (m_cnt + 1) % 65536;
`endif
    #1;
    check("sr_out", {28'd0, sr_out}, {28'd0, m_sr});
    check("sr_updated", {31'd0, sr_updated}, {31'd0, m_upd});
    check("upd_count", {16'd0, upd_count}, m_cnt);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_sr    = 4'd0;
    m_saved = 4'd0;
    m_upd   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_sr", {28'd0, sr_out}, 32'd0);
    check("rst_upd", {31'd0, sr_updated}, 32'd0);
    check("rst_cnt", {16'd0, upd_count}, 32'd0);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [32:0] sum;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    model_reset();
    rst_n = 1'b0;
    idle();
    #12;
    check("reset_sr", {28'd0, sr_out}, 32'd0);
    check("reset_fwd", {28'd0, sr_fwd}, 32'd0);
    check("reset_upd", {31'd0, sr_updated}, 32'd0);
    check("reset_cnt", {16'd0, upd_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arith with zero result and carry.
    drv(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("arith_fwd", {28'd0, sr_fwd}, 32'h6);
    cyc();
    check("arith_sr", {28'd0, sr_out}, 32'h6);
    idle();
    cyc();
    check("upd_pulse", {31'd0, sr_updated}, 32'd0);

    // Logic keeps V, mul keeps C and V.
    drv(1, 1, 3, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
    cyc();
    drv(1, 1, 1, 32'h8000_0000, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc();
    check("logic_sr", {28'd0, sr_out}, 32'hB);
    drv(1, 1, 2, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    check("mul_sr", {28'd0, sr_out}, 32'h3);

    // Blocked commits.
    drv(1, 1, 3, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0);
    cyc();
    drv(1, 1, 3, 0, 0, 0, 0, 4'hF, 0, 1, 0, 0);
    cyc();
    drv(1, 0, 3, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    cyc();
    drv(0, 1, 3, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    cyc();
    drv(1, 1, 3, 0, 0, 0, 0, 4'hF, 1, 1, 0, 0);
    cyc();
    check("blocked_sr", {28'd0, sr_out}, 32'h3);

    // Save with concurrent direct write, restore over a commit.
    drv(1, 1, 3, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0);
    cyc();
    drv(1, 1, 3, 0, 0, 0, 0, 4'b0101, 0, 0, 1, 0);
    cyc();
    drv(1, 1, 0, 32'h10, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("arith2_sr", {28'd0, sr_out}, 32'h2);
    drv(1, 1, 3, 0, 0, 0, 0, 4'hF, 0, 0, 1, 1);
    cyc();
    check("ret_sr", {28'd0, sr_out}, 32'h5);
    check("ret_noupd", {31'd0, sr_updated}, 32'd0);

    // Async reset right after an update, then return gives zero.
    drv(1, 1, 3, 0, 0, 0, 0, 4'b1111, 0, 0, 1, 0);
    cyc();
    do_reset();
    drv(1, 1, 3, 0, 0, 0, 0, 4'b1010, 0, 0, 0, 1);
    cyc();
    check("rst_saved", {28'd0, sr_out}, 32'd0);

    // Random traffic; arith flags from real two's-complement adds.
    for (int i = 0; i < 600; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? -a : $urandom;
      sum = {1'b0, a} + {1'b0, b};
      r = sum[31:0];
      drv($urandom_range(0, 7) != 0,
          $urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)),
          r, sum[32],
          (a[31] == b[31]) && (r[31] != a[31]),
          1'($urandom),
          4'($urandom),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0);
      cyc();
    end

`ifdef SR_UPDATE_COUNT_EN
    do_reset();
    drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++)
      cyc();
    check("cnt_wrap", {16'd0, upd_count}, 32'd0);
`else
    check("cnt_off", {16'd0, upd_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
Producer side of the NZCV status flags consumed by the condition-check logic. Computes N/Z/C/V from EX-stage ALU results when the S bit is set, and holds them in the architectural status register. Provides a same-cycle forwarded value so a conditional instruction in ID sees the flags of the instruction in EX. Saves and restores SR across exception entry/return.

Parameters:
WIDTH, 32, ALU result width in bits (N = result MSB, Z = result all-zero)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX-stage instruction valid
ex_s  input  1  instruction requests flag update (S bit)
ex_op_class  input  2  00 arith (NZCV), 01 logic (NZ, C from shifter, V kept), 10 mul (NZ only, C/V kept), 11 direct write (msr_data)
ex_result  input  WIDTH  ALU result
ex_carry  input  1  adder carry-out
ex_overflow  input  1  adder signed overflow
ex_shift_carry  input  1  barrel-shifter carry-out
msr_data  input  4  {N,Z,C,V} for direct write
stall  input  1  pipeline stall; EX instruction must not commit
flush  input  1  EX instruction squashed
exc_entry  input  1  exception entry: save SR
exc_return  input  1  exception return: restore SR
sr_out  output  4  registered {N,Z,C,V}
sr_fwd  output  4  combinational next value of SR
sr_updated  output  1  registered; 1 for one cycle after a committed flag update
upd_count  output  16  committed-update counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): sr=4'b0000, saved_sr=4'b0000, sr_updated=0, upd_count=0. Outputs valid immediately on assertion.
- commit = ex_valid & ex_s & ~stall & ~flush.
- Flag calc (combinational): n=ex_result[WIDTH-1]; z=(ex_result==0).
  - class 00: new={n,z,ex_carry,ex_overflow}
  - class 01: new={n,z,ex_shift_carry,sr.V}
  - class 10: new={n,z,sr.C,sr.V}
  - class 11: new=msr_data (ex_result ignored)
- Next-state priority per rising edge:
  1. exc_return: sr<=saved_sr; any commit in that cycle is discarded; saved_sr unchanged.
  2. else commit: sr<=new.
  3. else sr holds.
- exc_entry (without exc_return): saved_sr<=sr_fwd (includes a same-cycle commit). exc_entry and exc_return together: return wins, saved_sr unchanged.
- sr_fwd = value sr will take at the next edge per the priority above; equals sr_out when nothing commits. Zero-latency path; no register between inputs and sr_fwd.
- sr_updated<=1 on an edge where the commit updated sr (not overridden by exc_return), else 0.
- Latency: sr_out reflects an update one cycle after commit; sr_fwd reflects it in the same cycle.
- stall or flush with ex_s=1: no update, sr_updated=0. flush and stall together: no update.
- ex_valid=0: ex_s and other EX inputs ignored.
- Reset mid-operation clears everything, including saved_sr; the first edge after deassertion behaves normally.

Optional Feature:
SR_UPDATE_COUNT_EN
- Defined: upd_count is a 16-bit counter, +1 on every edge where sr_updated is set (same condition), wraps 16'hFFFF->16'h0000, reset 0.
- Undefined: no counter logic; upd_count tied to 16'h0000. Port list unchanged.

Test Plan:
- Arith with ex_result=0, ex_carry=1, ex_overflow=0, ex_s=1, valid -> sr_fwd=4'b0110 same cycle; sr_out=4'b0110 next cycle; sr_updated=1 for one cycle.
- sr=4'b0001. Logic op with ex_result=32'h80000000, ex_shift_carry=1 -> sr=4'b1011 (V kept). Then mul with result 5 -> sr=4'b0011.
- Commit with stall=1, then with flush=1, then with ex_s=0 -> sr unchanged, sr_updated=0, upd_count unchanged (if enabled).
- sr=4'b1000. exc_entry in the same cycle as a direct write msr_data=4'b0101 -> saved_sr=4'b0101. Later arith sets sr=4'b0010. exc_return with a concurrent commit -> sr=4'b0101 and the commit is discarded.
- Assert rst_n low asynchronously mid-cycle after updates -> sr_out=0 and sr_updated=0 before the next clock edge; saved_sr=0, verified by a subsequent exc_return giving sr=0.
- With SR_UPDATE_COUNT_EN, preload via 65536 commits -> upd_count wraps to 0. Without it, upd_count stays 0 throughout.
